// File: rtl/mux_port_arbiter.sv
// Stage-1 input arbiter for the 7-input crossbar mux: priority select with
// round-robin tie-break and age-based starvation override.
module mux_port_arbiter #(
    parameter int NumPorts      = 7,
    parameter int PriorityWidth = 8,
    parameter int AgeWidth      = 4,
    parameter int AgeLimit      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NumPorts-1:0]               req,
    input  logic [NumPorts*PriorityWidth-1:0] prio,
    input  logic                              out_stall,
    output logic [NumPorts-1:0]               grant,
    output logic [2:0]                        grant_index_q,
    output logic                              grant_valid_q
);

    localparam logic [AgeWidth-1:0] AgeMax = AgeWidth'(AgeLimit);

    logic [2:0]               rr_ptr_q, rr_ptr_d;
    logic [AgeWidth-1:0]      age_q [NumPorts];
    logic [AgeWidth-1:0]      age_d [NumPorts];
    logic [2:0]               grant_index_d;
    logic                     grant_valid_d;

    logic [PriorityWidth-1:0] max_prio;
    logic [NumPorts-1:0]      starve;
    logic [NumPorts-1:0]      top;
    logic [NumPorts-1:0]      cand;
    logic [3:0]               scan_idx;
    logic [2:0]               gidx;
    logic                     found;
    logic                     fire;

    always_comb begin
        max_prio = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (req[i] && prio[i*PriorityWidth +: PriorityWidth] > max_prio) begin
                max_prio = prio[i*PriorityWidth +: PriorityWidth];
            end
        end
        starve = '0;
        top    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            starve[i] = req[i] && (age_q[i] == AgeMax);
            top[i]    = req[i] && (prio[i*PriorityWidth +: PriorityWidth] == max_prio);
        end
        // Starving ports override priority entirely
        cand = (|starve) ? starve : top;
    end

    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_idx = '0;
        for (int k = 0; k < NumPorts; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + 4'(k);
            if (scan_idx >= 4'(NumPorts)) begin
                scan_idx = scan_idx - 4'(NumPorts);
            end
            if (!found && cand[scan_idx[2:0]]) begin
                found = 1'b1;
                gidx  = scan_idx[2:0];
            end
        end
        fire  = found && !rst && !out_stall && (|req);
        grant = '0;
        if (fire) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        age_d         = age_q;
        grant_index_d = grant_index_q;
        grant_valid_d = fire;
        if (fire) begin
            rr_ptr_d      = (gidx == 3'(NumPorts-1)) ? 3'd0 : gidx + 3'd1;
            grant_index_d = gidx;
            for (int i = 0; i < NumPorts; i++) begin
                if (3'(i) == gidx) begin
                    age_d[i] = '0;
                end else if (req[i]) begin
                    age_d[i] = (age_q[i] >= AgeMax) ? AgeMax : age_q[i] + 1'b1;
                end else begin
                    age_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            grant_index_q <= '0;
            grant_valid_q <= 1'b0;
            for (int i = 0; i < NumPorts; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_index_q <= grant_index_d;
            grant_valid_q <= grant_valid_d;
            for (int i = 0; i < NumPorts; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed bench for mux_port_arbiter: reset, priority, round-robin,
// starvation, stall, empty masking, age drain and mid-run reset.
module tb_mux_port_arbiter;

    logic        clk;
    logic        rst;
    logic [6:0]  req;
    logic [55:0] prio;
    logic        out_stall;
    logic [6:0]  grant;
    logic [2:0]  grant_index_q;
    logic        grant_valid_q;

    int checks;
    int failures;

    mux_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .prio         (prio),
        .out_stall    (out_stall),
        .grant        (grant),
        .grant_index_q(grant_index_q),
        .grant_valid_q(grant_valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_prio_all(input logic [7:0] p);
        for (int i = 0; i < 7; i++) prio[i*8 +: 8] = p;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        out_stall = 1'b0;
        edge_wait();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_stall = 1'b0;
        req = 7'h7F;
        set_prio_all(8'd3);
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (grant !== 7'b0) begin
                failures++;
                $display("FAIL reset_grant cyc=%0d got=%b exp=0000000", c, grant);
            end
            edge_wait();
            checks++;
            if (grant_valid_q !== 1'b0 || grant_index_q !== 3'd0) begin
                failures++;
                $display("FAIL reset_regs cyc=%0d got v=%b i=%0d exp v=0 i=0",
                         c, grant_valid_q, grant_index_q);
            end
        end
        rst = 1'b0;
        #3;
        checks++;
        if (grant !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0000001", grant);
        end
        edge_wait();
        checks++;
        if (grant_valid_q !== 1'b1 || grant_index_q !== 3'd0) begin
            failures++;
            $display("FAIL reset_release_regs got v=%b i=%0d exp v=1 i=0",
                     grant_valid_q, grant_index_q);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_prio_all(8'd0);
        prio[1*8 +: 8] = 8'd5;
        prio[3*8 +: 8] = 8'd9;
        req = 7'b0001010;
        #3;
        checks++;
        if (grant !== 7'b0001000) begin
            failures++;
            $display("FAIL prio_grant got=%b exp=0001000", grant);
        end
        edge_wait();
        checks++;
        if (grant_valid_q !== 1'b1 || grant_index_q !== 3'd3) begin
            failures++;
            $display("FAIL prio_regs got v=%b i=%0d exp v=1 i=3",
                     grant_valid_q, grant_index_q);
        end
        // Equal priorities now: the round-robin pointer must sit at 4
        req = 7'h7F;
        set_prio_all(8'd4);
        #3;
        checks++;
        if (grant !== 7'b0010000) begin
            failures++;
            $display("FAIL prio_rrptr got=%b exp=0010000", grant);
        end
        edge_wait();
    endtask

    task automatic test_tie_rr();
        int e;
        do_reset();
        req = 7'h7F;
        set_prio_all(8'd4);
        for (int k = 0; k < 8; k++) begin
            e = k % 7;
            #3;
            checks++;
            if (grant !== 7'(1 << e)) begin
                failures++;
                $display("FAIL rr_grant cyc=%0d got=%b exp_idx=%0d", k, grant, e);
            end
            edge_wait();
            checks++;
            if (grant_index_q !== 3'(e) || grant_valid_q !== 1'b1) begin
                failures++;
                $display("FAIL rr_regs cyc=%0d got i=%0d v=%b exp i=%0d v=1",
                         k, grant_index_q, grant_valid_q, e);
            end
        end
    endtask

    task automatic test_starvation();
        int e;
        do_reset();
        set_prio_all(8'd0);
        prio[0*8 +: 8] = 8'd1;
        prio[6*8 +: 8] = 8'd200;
        req = 7'b1000001;
        for (int k = 0; k < 10; k++) begin
            e = (k == 8) ? 0 : 6;
            #3;
            checks++;
            if (grant !== 7'(1 << e)) begin
                failures++;
                $display("FAIL starve_grant cyc=%0d got=%b exp_idx=%0d", k + 1, grant, e);
            end
            edge_wait();
        end
    endtask

    task automatic test_stall();
        int nxt;
        int last;
        logic st;
        logic [6:0] eg;
        do_reset();
        req = 7'h7F;
        set_prio_all(8'd4);
        nxt = 0;
        last = 0;
        for (int k = 0; k < 10; k++) begin
            st = (k >= 3 && k <= 5);
            out_stall = st;
            if (st) begin
                eg = 7'b0;
            end else begin
                eg = 7'(1 << nxt);
                last = nxt;
                nxt = (nxt + 1) % 7;
            end
            #3;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL stall_grant cyc=%0d got=%b exp=%b", k, grant, eg);
            end
            edge_wait();
            checks++;
            if (grant_valid_q !== !st || grant_index_q !== 3'(last)) begin
                failures++;
                $display("FAIL stall_regs cyc=%0d got v=%b i=%0d exp v=%b i=%0d",
                         k, grant_valid_q, grant_index_q, !st, last);
            end
        end
        out_stall = 1'b0;
        // Ages must hold across a stall: 4 grants, 3 stalls, 4 grants, then port 0
        do_reset();
        set_prio_all(8'd0);
        prio[0*8 +: 8] = 8'd1;
        prio[6*8 +: 8] = 8'd200;
        req = 7'b1000001;
        for (int k = 0; k < 12; k++) begin
            st = (k >= 4 && k <= 6);
            out_stall = st;
            eg = st ? 7'b0 : ((k == 11) ? 7'b0000001 : 7'b1000000);
            #3;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL stall_age cyc=%0d got=%b exp=%b", k, grant, eg);
            end
            edge_wait();
        end
        out_stall = 1'b0;
    endtask

    task automatic test_empty();
        do_reset();
        req = 7'b0;
        set_prio_all(8'hFF);
        #3;
        checks++;
        if (grant !== 7'b0) begin
            failures++;
            $display("FAIL empty_grant got=%b exp=0000000", grant);
        end
        edge_wait();
        checks++;
        if (grant_valid_q !== 1'b0) begin
            failures++;
            $display("FAIL empty_valid got=%b exp=0", grant_valid_q);
        end
        // Lone low-priority requester wins over idle high-priority ports
        prio[5*8 +: 8] = 8'd0;
        req = 7'b0100000;
        #3;
        checks++;
        if (grant !== 7'b0100000) begin
            failures++;
            $display("FAIL single_req got=%b exp=0100000", grant);
        end
        edge_wait();
        checks++;
        if (grant_index_q !== 3'd5 || grant_valid_q !== 1'b1) begin
            failures++;
            $display("FAIL single_regs got i=%0d v=%b exp i=5 v=1",
                     grant_index_q, grant_valid_q);
        end
    endtask

    task automatic test_age_drain();
        logic [6:0] eg;
        do_reset();
        set_prio_all(8'd0);
        prio[0*8 +: 8] = 8'd1;
        prio[6*8 +: 8] = 8'd200;
        req = 7'b1000001;
        for (int k = 0; k < 7; k++) edge_wait();
        // Port 0 drains for one cycle and must lose its accumulated age
        req = 7'b1000000;
        edge_wait();
        req = 7'b1000001;
        for (int k = 0; k < 9; k++) begin
            eg = (k == 8) ? 7'b0000001 : 7'b1000000;
            #3;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL age_drain cyc=%0d got=%b exp=%b", k, grant, eg);
            end
            edge_wait();
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] eg;
        do_reset();
        set_prio_all(8'd0);
        prio[0*8 +: 8] = 8'd1;
        prio[6*8 +: 8] = 8'd200;
        req = 7'b1000001;
        for (int k = 0; k < 5; k++) edge_wait();
        rst = 1'b1;
        #3;
        checks++;
        if (grant !== 7'b0) begin
            failures++;
            $display("FAIL midrst_grant got=%b exp=0000000", grant);
        end
        edge_wait();
        checks++;
        if (grant_valid_q !== 1'b0 || grant_index_q !== 3'd0) begin
            failures++;
            $display("FAIL midrst_regs got v=%b i=%0d exp v=0 i=0",
                     grant_valid_q, grant_index_q);
        end
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            eg = (k == 8) ? 7'b0000001 : 7'b1000000;
            #3;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL midrst_seq cyc=%0d got=%b exp=%b", k, grant, eg);
            end
            edge_wait();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = '0;
        prio = '0;
        out_stall = 1'b0;
        #1;
        test_reset();
        test_priority();
        test_tie_rr();
        test_starvation();
        test_stall();
        test_empty();
        test_age_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
